// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch PC controller: one outstanding imem request, zero-latency
// response pass-through to decode, hold buffer for stalls, branch redirect/squash.
module fetch_pc_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        take_branch,
   input  logic [63:0] branch_target,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready,
   output logic        misalign_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        squash_q, squash_d;
   logic [31:0] hold_instr_q, hold_instr_d;

   logic        misaligned;
   logic        redirect;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic [63:0] pc_inc;

   assign pc_inc     = pc_q + 64'd4;
   assign misaligned = take_branch && (branch_target[1:0] != 2'b00);
   assign redirect   = take_branch && !misaligned;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      squash_d     = squash_q;
      hold_instr_d = hold_instr_q;
      imem_req     = 1'b0;
      imem_addr    = '0;
      fetch_valid  = 1'b0;
      fetch_instr  = '0;
      misalign_err = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (redirect) pc_d = branch_target;
         end

         S_REQ: begin
            imem_req     = 1'b1;
            imem_addr    = pc_q;
            misalign_err = misaligned;
            if (redirect) pc_d = branch_target;
            // A grant in the redirect cycle fetches the old address; squash its response.
            if (imem_gnt) begin
               state_d  = S_WAIT;
               squash_d = redirect;
            end
         end

         S_WAIT: begin
            misalign_err = misaligned;
            if (imem_rvalid) begin
               if (redirect) begin
                  pc_d     = branch_target;
                  squash_d = 1'b0;
                  state_d  = S_REQ;
               end else if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = S_REQ;
               end else begin
                  fetch_valid = 1'b1;
                  fetch_instr = imem_rdata;
                  if (!take_branch && if_ready) begin
                     pc_d    = pc_inc;
                     state_d = S_REQ;
                  end else begin
                     hold_instr_d = imem_rdata;
                     state_d      = S_HOLD;
                  end
               end
            end else if (redirect) begin
               pc_d     = branch_target;
               squash_d = 1'b1;
            end
         end

         S_HOLD: begin
            misalign_err = misaligned;
            fetch_valid  = 1'b1;
            fetch_instr  = hold_instr_q;
            if (redirect) begin
               pc_d    = branch_target;
               state_d = S_REQ;
            end else if (!take_branch && if_ready) begin
               pc_d    = pc_inc;
               state_d = S_REQ;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if_valid = fetch_valid && !take_branch;
      if_pc    = if_valid ? pc_q : '0;
      if_instr = if_valid ? fetch_instr : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         squash_q     <= 1'b0;
         hold_instr_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         state_q      <= state_d;
         pc_q         <= pc_d;
         squash_q     <= squash_d;
         hold_instr_q <= hold_instr_d;
      end
   end

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port take_branch  input  1  resolved-taken redirect request from the branch stage.
REQ-005 SHALL have port branch_target  input  64  redirect address, valid while take_branch=1.
REQ-006 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-007 SHALL have port imem_addr  output  64  request address.
REQ-008 SHALL have port imem_gnt  input  1  request accepted in this cycle.
REQ-009 SHALL have port imem_rvalid  input  1  response valid; exactly one per granted request, at least 1 cycle after grant.
REQ-010 SHALL have port imem_rdata  input  32  response instruction.
REQ-011 SHALL have port if_valid  output  1  fetched instruction valid toward decode.
REQ-012 SHALL have port if_pc  output  64  PC of the presented instruction.
REQ-013 SHALL have port if_instr  output  32  presented instruction.
REQ-014 SHALL have port if_ready  input  1  decode accepts; transfer when if_valid and if_ready are both 1.
REQ-015 SHALL have port misalign_err  output  1  one-cycle pulse on a rejected misaligned redirect.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT, HOLD, plus a squash flag and a 64-bit pc register.
REQ-017 IDLE: outputs low, one cycle after reset release, then REQ.
REQ-018 REQ: imem_req=1, imem_addr=pc; on imem_gnt go to WAIT; else stay in REQ.
REQ-019 WAIT: on imem_rvalid with squash=0, present if_valid=1, if_pc=pc, if_instr=imem_rdata in that cycle (zero-latency pass-through).
REQ-020 In WAIT, if the transfer completes in the rvalid cycle, pc <= pc+4 and go to REQ; otherwise capture the instruction and go to HOLD.
REQ-021 HOLD: if_valid=1 with if_pc and if_instr stable until transfer; on transfer pc <= pc+4 and go to REQ.
REQ-022 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
REQ-023 Redirect is a cycle with take_branch=1 and branch_target[1:0]=0; it SHALL load pc <= branch_target and take priority over pc+4.
REQ-024 A cycle with take_branch=1 and branch_target[1:0]!=0 SHALL pulse misalign_err for that cycle and leave pc and state unchanged.
REQ-025 if_valid SHALL be forced to 0 combinationally in any cycle where take_branch=1, so no transfer occurs in that cycle.
REQ-026 Redirect in REQ without gnt: stay in REQ; imem_addr shows the target from the next cycle.
REQ-027 Redirect in REQ with gnt: go to WAIT with squash=1.
REQ-028 Redirect in WAIT without rvalid: set squash=1 and stay in WAIT.
REQ-029 Redirect in WAIT with rvalid: discard the response and go to REQ.
REQ-030 Redirect in HOLD: drop the held instruction and go to REQ.
REQ-031 In WAIT with squash=1, rvalid SHALL be discarded (if_valid=0), squash cleared, and the state goes to REQ.
REQ-032 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.
REQ-033 Only one request SHALL be outstanding at a time; imem_req=0 in WAIT and HOLD.

Reset
REQ-034 While rst_n=0, all of the following SHALL hold immediately and asynchronously: state=IDLE, pc=RESET_PC, squash=0.
REQ-035 While rst_n=0, all outputs SHALL be 0: imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err.
REQ-036 A reset mid-transaction SHALL abandon any outstanding request; the first request after release SHALL go to RESET_PC.

Verification
REQ-037 Reset release, gnt and rvalid each 1 cycle later, if_ready=1 -> requests at 0x0, 0x4, 0x8 and if_pc sequence 0,4,8.
REQ-038 if_ready=0 for 3 cycles after rvalid of instr 0x00000013 at pc 0x10 -> if_valid/if_pc/if_instr held stable in HOLD; pc becomes 0x14 only after the transfer.
REQ-039 take_branch=1, target 0x200 in the cycle after gnt of pc 0x8; rvalid 2 cycles later -> response discarded, no if_valid, next imem_addr=0x200.
REQ-040 take_branch=1, target 0x102 -> misalign_err pulse of 1 cycle, pc unchanged, fetch continues sequentially.
REQ-041 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one transfer -> next imem_addr=0x0.
REQ-042 rst_n asserted in WAIT and a stale rvalid arriving during IDLE -> rvalid ignored, first request after release at RESET_PC.
